// File: rtl/ctrl_slave_issue_fifo_pkg.sv
// Shared backend definitions for the 2-wide in, 1-wide out issue queue.
package ctrl_slave_issue_fifo_pkg;

   localparam int unsigned IQ_ENQ_WIDTH = 2;
   localparam int unsigned IQ_DATA_W    = 64;

   typedef logic [IQ_DATA_W-1:0] uop_t;

   // Number of valid slots in a 2-wide enqueue group.
   function automatic logic [1:0] popcount2(input logic [IQ_ENQ_WIDTH-1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

endpackage

// File: rtl/ctrl_slave_issue_fifo_if.sv
// Ctrl slave handshake plus enqueue/dequeue bus of the issue queue.
interface ctrl_slave_issue_fifo_if
   import ctrl_slave_issue_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = IQ_DATA_W
);
   logic                             ctrl_pause;
   logic                             ctrl_flush;
   logic                             ctrl_pauseReq;
   logic                             ctrl_flushReq;
   logic [IQ_ENQ_WIDTH-1:0]          enq_valid;
   logic [IQ_ENQ_WIDTH*DATA_W-1:0]   enq_data;
   logic                             deq_valid;
   logic [DATA_W-1:0]                deq_data;
   logic                             deq_ready;

   modport slave (
      input  ctrl_pause, ctrl_flush, enq_valid, enq_data, deq_ready,
      output ctrl_pauseReq, ctrl_flushReq, deq_valid, deq_data
   );

   modport master (
      output ctrl_pause, ctrl_flush, enq_valid, enq_data, deq_ready,
      input  ctrl_pauseReq, ctrl_flushReq, deq_valid, deq_data
   );
endinterface

// File: rtl/ctrl_slave_fifo_mem.sv
// DEPTH x DATA_W storage: two write ports, one asynchronous read port, no reset.
module ctrl_slave_fifo_mem #(
   parameter  int unsigned DEPTH  = 8,
   parameter  int unsigned DATA_W = 64,
   localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we0,
   input  logic [PTR_W-1:0]  waddr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              we1,
   input  logic [PTR_W-1:0]  waddr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [PTR_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write addresses never collide: port 1 always targets port 0 address + 1.
   always_ff @(posedge clk) begin
      if (we0) mem[waddr0] <= wdata0;
      if (we1) mem[waddr1] <= wdata1;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ctrl_slave_issue_fifo.sv
// In-order issue queue on the slave end of Ctrl: 2-wide enqueue, 1-wide issue,
// raises pauseReq whenever a full 2-wide enqueue could not be absorbed.
module ctrl_slave_issue_fifo
   import ctrl_slave_issue_fifo_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned DATA_W = IQ_DATA_W
) (
   input  logic                   clk,
   input  logic                   rst_n,
   ctrl_slave_issue_fifo_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;
   logic              deq_valid_q;
   logic              pause_req_q;

   logic              en_c;
   logic              fire_c;
   logic [1:0]        n_enq_c;
   logic [CNT_W-1:0]  count_next_c;
   logic [DATA_W-1:0] slot0_c, slot1_c;
   logic              we0_c, we1_c;
   logic [DATA_W-1:0] wdata0_c;
   logic [DATA_W-1:0] rdata_c;

   assign slot0_c = bus.enq_data[DATA_W-1:0];
   assign slot1_c = bus.enq_data[2*DATA_W-1:DATA_W];

   // Enqueue and issue qualification; flush dominates both.
   always_comb begin
      en_c         = !bus.ctrl_pause && !pause_req_q && !bus.ctrl_flush;
      fire_c       = deq_valid_q && bus.deq_ready && !bus.ctrl_flush;
      n_enq_c      = 2'd0;
      we0_c        = 1'b0;
      we1_c        = 1'b0;
      wdata0_c     = slot0_c;
      if (en_c) begin
         n_enq_c = popcount2(bus.enq_valid);
         we0_c   = |bus.enq_valid;
         we1_c   = &bus.enq_valid;
         // A lone slot-1 op is packed down into the tail entry.
         if (!bus.enq_valid[0]) wdata0_c = slot1_c;
      end
      count_next_c = count_q + CNT_W'(n_enq_c) - CNT_W'(fire_c);
   end

   ctrl_slave_fifo_mem #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk    (clk),
      .we0    (we0_c),
      .waddr0 (tail_q),
      .wdata0 (wdata0_c),
      .we1    (we1_c),
      .waddr1 (tail_q + PTR_W'(1)),
      .wdata1 (slot1_c),
      .raddr  (head_q),
      .rdata  (rdata_c)
   );

   // Pointers, occupancy and the registered status outputs derived from count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         deq_valid_q <= 1'b0;
         pause_req_q <= 1'b0;
      end else if (bus.ctrl_flush) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         deq_valid_q <= 1'b0;
         pause_req_q <= 1'b0;
      end else begin
         head_q      <= head_q + PTR_W'(fire_c);
         tail_q      <= tail_q + PTR_W'(n_enq_c);
         count_q     <= count_next_c;
         deq_valid_q <= (count_next_c != '0);
         pause_req_q <= (count_next_c > CNT_W'(DEPTH - 2));
      end
   end

   assign bus.deq_valid     = deq_valid_q;
   assign bus.deq_data      = rdata_c;
   assign bus.ctrl_pauseReq = pause_req_q;
   assign bus.ctrl_flushReq = 1'b0;

   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(DEPTH));

   a_no_flush_req : assert property (@(posedge clk) disable iff (!rst_n)
      bus.ctrl_flushReq == 1'b0);

   a_ptr_count : assert property (@(posedge clk) disable iff (!rst_n)
      PTR_W'(tail_q - head_q) == PTR_W'(count_q));

endmodule
